and_gate: RTL and testbench

- Three-input AND primitive with a combinational result and a registered copy.
- Adds a small input-combination coverage tracker on lane 0.
- Used as a leaf logic cell and as a bring-up/teaching block for truth-table verification.
- One clock domain (clk), synchronous active-high reset (rst).

---
 rtl/and_gate_pkg.sv | 14 +
 rtl/and_gate.sv | 44 ++++
 tb/tb_and_gate.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/and_gate_pkg.sv
// rtl/and_gate_pkg.sv - shared constants and helpers for the and_gate cell
package and_gate_pkg;

    localparam int COMBO_COUNT = 8;

    // One-hot mask for a 3-bit lane-0 input combination {a, b, c}
    function automatic logic [COMBO_COUNT-1:0] combo_onehot(input logic [2:0] idx);
        logic [COMBO_COUNT-1:0] mask;
        mask = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/and_gate.sv
// rtl/and_gate.sv - three-input AND cell with registered copy and lane-0 coverage tracker
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int REG_OUT_RST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       a,
    input  logic [WIDTH-1:0]       b,
    input  logic [WIDTH-1:0]       c,
    output logic [WIDTH-1:0]       y,
    output logic [WIDTH-1:0]       y_q,
    output logic [COMBO_COUNT-1:0] combo_seen,
    output logic                   all_seen
);

    localparam logic RST_BIT = REG_OUT_RST[0];

    logic [2:0] combo_idx;

    assign y         = a & b & c;
    assign combo_idx = {a[0], b[0], c[0]};
    assign all_seen  = &combo_seen;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= {WIDTH{RST_BIT}};
        end else begin
            y_q <= a & b & c;
        end
    end

    // Sticky bitmap: bits only accumulate until the next reset
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_seen <= '0;
        end else begin
            combo_seen <= combo_seen | combo_onehot(combo_idx);
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// tb/tb_and_gate.sv - directed truth-table and sequence bench for and_gate
module tb_and_gate;

    logic       clk;
    logic       rst;
    logic       a1, b1, c1;
    logic       y1, y1_q;
    logic [7:0] seen1;
    logic       all1;
    logic [3:0] a4, b4, c4;
    logic [3:0] y4, y4_q;
    logic [7:0] seen4;
    logic       all4;

    int errors;
    int checks;

    typedef struct {
        logic a;
        logic b;
        logic c;
        logic y;
    } vec_t;

    vec_t tt [8];

    and_gate #(.WIDTH(1), .REG_OUT_RST(0)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .a          (a1),
        .b          (b1),
        .c          (c1),
        .y          (y1),
        .y_q        (y1_q),
        .combo_seen (seen1),
        .all_seen   (all1)
    );

    and_gate #(.WIDTH(4), .REG_OUT_RST(1)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .a          (a4),
        .b          (b4),
        .c          (c4),
        .y          (y4),
        .y_q        (y4_q),
        .combo_seen (seen4),
        .all_seen   (all4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [2:0] abc);
        {a1, b1, c1} = abc;
    endtask

    initial begin
        logic [7:0] exp_seen;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        drive1(3'b000);
        a4 = '0; b4 = '0; c4 = '0;

        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tt[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tt[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tt[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        // reset state
        step();
        step();
        check("rst_y_q", 32'(y1_q), 32'h0);
        check("rst_seen", 32'(seen1), 32'h00);
        check("rst_all", 32'(all1), 32'h0);
        check("rst_y4_q", 32'(y4_q), 32'hF);
        rst = 1'b0;

        // truth table
        for (int i = 0; i < 8; i++) begin
            a1 = tt[i].a; b1 = tt[i].b; c1 = tt[i].c;
            #10;
            check($sformatf("tt_y_%0d", i), 32'(y1), 32'(tt[i].y));
        end

        // registered path
        drive1(3'b111);
        step();
        check("reg_y_q_hi", 32'(y1_q), 32'h1);
        drive1(3'b110);
        step();
        check("reg_y_q_lo", 32'(y1_q), 32'h0);

        // reset held for two cycles with all inputs high
        drive1(3'b111);
        rst = 1'b1;
        #1;
        check("rst2_y_pre", 32'(y1), 32'h1);
        step();
        check("rst2_y_q", 32'(y1_q), 32'h0);
        check("rst2_seen", 32'(seen1), 32'h00);
        check("rst2_y_e1", 32'(y1), 32'h1);
        step();
        check("rst2_y_q_e2", 32'(y1_q), 32'h0);
        check("rst2_y_e2", 32'(y1), 32'h1);
        rst = 1'b0;
        step();
        check("rst2_release_y_q", 32'(y1_q), 32'h1);
        check("rst2_release_seen", 32'(seen1), 32'h80);

        // coverage walk from a clean start
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_seen = 8'h00;
        for (int k = 0; k < 8; k++) begin
            drive1(3'(k));
            #1;
            check($sformatf("cov_all_pre_%0d", k), 32'(all1), 32'h0);
            step();
            exp_seen[k] = 1'b1;
            check($sformatf("cov_seen_%0d", k), 32'(seen1), 32'(exp_seen));
            check($sformatf("cov_all_%0d", k), 32'(all1), 32'(k == 7));
        end
        drive1(3'b111);
        step();
        step();
        check("cov_repeat_seen", 32'(seen1), 32'hFF);
        check("cov_repeat_all", 32'(all1), 32'h1);

        // mid-run reset after partial coverage
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive1(3'(k));
            step();
        end
        check("mid_seen_0f", 32'(seen1), 32'h0F);
        drive1(3'b111);
        rst = 1'b1;
        step();
        check("mid_rst_seen", 32'(seen1), 32'h00);
        check("mid_rst_all", 32'(all1), 32'h0);
        rst = 1'b0;
        exp_seen = 8'h00;
        for (int k = 7; k >= 0; k--) begin
            drive1(3'(k));
            step();
            exp_seen[k] = 1'b1;
            check($sformatf("mid_reacc_%0d", k), 32'(seen1), 32'(exp_seen));
        end
        check("mid_reacc_all", 32'(all1), 32'h1);

        // multi-lane
        a4 = 4'b1111; b4 = 4'b1010; c4 = 4'b1100;
        #1;
        check("lane4_y", 32'(y4), 32'h8);
        step();
        check("lane4_y_q", 32'(y4_q), 32'h8);
        check("lane4_seen", 32'(seen4), 32'h11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
